spi_tx_responder: RTL

- FPGA-side SPI peripheral transmitter: return path to the MCU over the same SPI link whose receive side raises a memory write enable at end of frame.
- Shifts one WIDTH-bit word (game status, e.g. score or collision flags) MSB-first on sdo while the MCU holds cs high and clocks sck.
- Mode 0 (CPOL=0, CPHA=0). sck and cs are asynchronous inputs, synchronized and edge-detected in the clk domain.
- Word source is a one-entry holding buffer loaded through a valid/ready handshake.

---
 rtl/spi_tx_responder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_tx_responder.sv
// Purpose : SPI mode-0 peripheral transmitter; shifts one WIDTH-bit status word MSB-first on o_sdo per cs frame.
// Latency : first bit on o_sdo SYNC_STAGES+1 clk after pin cs rises; each later bit 1 clk after the synchronized sck fall.
// Backpr. : one-entry holding buffer; o_tx_ready low while full or in S_WAIT; a full buffer is never overwritten.
//
// Ports:
//   i_clk        system clock (f_clk >= 8*f_sck)
//   i_reset      synchronous, active-high reset
//   i_sck        SPI clock from the MCU (asynchronous)
//   i_cs         chip select from the MCU, active-high (asynchronous)
//   o_sdo        serial data to the MCU (MISO); 0 outside a frame
//   i_tx_data    word to send in a later frame
//   i_tx_valid   i_tx_data valid
//   o_tx_ready   holding buffer can accept; transfer on i_tx_valid && o_tx_ready at posedge
//   o_busy       frame in progress (S_SHIFT)
//   o_done       one-cycle pulse at frame end
//   o_frame_err  qualified by o_done: underrun, or sample-edge count != WIDTH
module spi_tx_responder #(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL        = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sck,
    input  logic             i_cs,
    output logic             o_sdo,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_frame_err
);

    // Count saturates at WIDTH+1 so that any overrun stays distinguishable
    // from a correct frame.
    localparam int CNT_W   = $clog2(WIDTH + 2);
    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;
    logic                   w_sck_s;
    logic                   w_cs_s;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '0;
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
            r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;

    // ------------------------------------------------------------------
    // Synchronizer priming. The sync flops come out of reset at 0, so
    // for SYNC_STAGES cycles cs_s reads low even if the pin is high.
    // S_WAIT must not trust cs_s until the chain holds real pin samples,
    // otherwise a frame already in progress at reset would look like a
    // fresh cs rise.
    // ------------------------------------------------------------------
    logic [PRIME_W-1:0] r_prime;
    logic               w_primed;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prime <= '0;
        end else if (r_prime != PRIME_W'(SYNC_STAGES)) begin
            r_prime <= r_prime + 1'b1;
        end
    end

    assign w_primed = (r_prime == PRIME_W'(SYNC_STAGES));

    // ------------------------------------------------------------------
    // Frame control FSM
    // ------------------------------------------------------------------
    logic             r_cs_pend;
    logic             w_start;
    logic             w_cnt_inc;
    logic             w_shift;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_underrun;
    logic [WIDTH-1:0] r_buf;
    logic             r_buf_full;
    logic             w_accept;
    logic             w_load;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cnt_inc   = 1'b0;
        w_shift     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_frame_err = 1'b0;
        o_sdo       = 1'b0;
        o_tx_ready  = 1'b0;

        case (r_state)
            S_WAIT: begin
                if (w_primed && !w_cs_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                o_tx_ready = ~r_buf_full;
                if (w_cs_rise || r_cs_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                o_tx_ready = ~r_buf_full;
                o_busy     = 1'b1;
                o_sdo      = r_shreg[WIDTH-1];
                // cs fall ends the frame; an sck edge landing in the same
                // cycle is deliberately dropped.
                if (w_cs_fall) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_inc = w_sck_rise;
                    w_shift   = w_sck_fall;
                end
            end
            S_DONE: begin
                o_tx_ready  = ~r_buf_full;
                o_done      = 1'b1;
                o_frame_err = r_underrun | (r_cnt != CNT_W'(WIDTH));
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_WAIT;
            end
        endcase
    end

    // A cs rise seen during S_DONE has already left the edge detector by
    // the time S_IDLE runs; remember it for exactly one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cs_pend <= 1'b0;
        end else begin
            r_cs_pend <= (r_state == S_DONE) && w_cs_rise;
        end
    end

    // ------------------------------------------------------------------
    // Holding buffer. Accept only when empty; a frame start drains it.
    // Accept and drain are mutually exclusive (empty vs. full), so a word
    // offered in the cs-rise cycle of an underrun frame lands in the
    // buffer for the next frame rather than joining the current one.
    // ------------------------------------------------------------------
    assign w_accept = i_tx_valid & o_tx_ready;
    assign w_load   = w_start & r_buf_full;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf_full <= 1'b0;
            r_buf      <= '0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf      <= i_tx_data;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shift register and sample-edge counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg    <= {WIDTH{FILL}};
            r_cnt      <= '0;
            r_underrun <= 1'b0;
        end else if (w_start) begin
            r_shreg    <= r_buf_full ? r_buf : {WIDTH{FILL}};
            r_underrun <= ~r_buf_full;
            r_cnt      <= '0;
        end else begin
            // MCU samples on sck rise; the next bit is presented on sck fall.
            if (w_shift) begin
                r_shreg <= {r_shreg[WIDTH-2:0], FILL};
            end
            if (w_cnt_inc && (r_cnt != CNT_W'(WIDTH + 1))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
